// File: rtl/mem_dev.sv
// SDRAM-style device responder: decodes the controller command bus, holds one open
// row, stores data in an internal array and checks command timing and refresh rules.
module mem_dev #(
    parameter int ROW_W        = 4,
    parameter int COL_W        = 12,
    parameter int DATA_W       = 32,
    parameter int T_RCD        = 5,
    parameter int CL           = 2,
    parameter int T_RP         = 4,
    parameter int T_RFC        = 5,
    parameter int REF_INTERVAL = 320
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cs_n,
    input  logic [2:0]         command,
    input  logic [ROW_W-1:0]   RA,
    input  logic [COL_W-1:0]   CA,
    inout  wire  [DATA_W-1:0]  DQ,
    output logic               rd_vld,
    output logic               row_open,
    output logic [ROW_W-1:0]   open_row,
    output logic               ref_overdue,
    output logic               err_vld,
    output logic [2:0]         err_code,
    output logic [7:0]         err_cnt
);

    localparam int ADDR_W = ROW_W + COL_W;
    localparam int DEPTH  = 1 << ADDR_W;
    localparam int WAIT_W = 8;
    localparam int REF_W  = $clog2(REF_INTERVAL + 1);

    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_ACT     = 3'd1;
    localparam logic [2:0] CMD_READ    = 3'd2;
    localparam logic [2:0] CMD_WRITE   = 3'd3;
    localparam logic [2:0] CMD_PRE     = 3'd4;
    localparam logic [2:0] CMD_REFRESH = 3'd5;

    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_TIMING   = 3'd1;
    localparam logic [2:0] ERR_NO_ROW   = 3'd2;
    localparam logic [2:0] ERR_ROW_MISS = 3'd3;
    localparam logic [2:0] ERR_ACT_OPEN = 3'd4;
    localparam logic [2:0] ERR_REF_OPEN = 3'd5;
    localparam logic [2:0] ERR_BAD_CMD  = 3'd6;
    localparam logic [2:0] ERR_BUS      = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVATING,
        S_ACTIVE,
        S_PRECHARGING,
        S_REFRESHING
    } state_t;

    state_t              state_reg, state_next;
    logic [WAIT_W-1:0]   wait_cnt_reg, wait_cnt_next;
    logic [ROW_W-1:0]    open_row_reg, open_row_next;
    logic                row_open_reg, row_open_next;
    logic [2:0]          err_code_reg, err_next;
    logic                err_vld_reg;
    logic [7:0]          err_cnt_reg;
    logic [REF_W-1:0]    ref_timer_reg;
    logic                ref_overdue_reg;

    logic [2:0]          cmd;
    logic                bad_cmd;
    logic                in_wait;
    logic                row_hit;
    logic                do_read;
    logic                do_write;
    logic                do_refresh;
    logic [ADDR_W-1:0]   mem_addr;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DATA_W-1:0]   pipe_data_reg [CL];
    logic [CL-1:0]       pipe_vld_reg;

    assign cmd      = cs_n ? CMD_NOP : command;
    assign bad_cmd  = (cmd == 3'd6) || (cmd == 3'd7);
    assign in_wait  = (state_reg == S_ACTIVATING) || (state_reg == S_PRECHARGING) ||
                      (state_reg == S_REFRESHING);
    assign row_hit  = (RA == open_row_reg);
    assign mem_addr = {open_row_reg, CA};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            wait_cnt_reg <= '0;
            open_row_reg <= '0;
            row_open_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wait_cnt_reg <= wait_cnt_next;
            open_row_reg <= open_row_next;
            row_open_reg <= row_open_next;
        end
    end

    // Error priority: bad opcode, then timing, then whatever the current state rejects.
    // An errored command leaves state, array and read pipeline untouched.
    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        open_row_next = open_row_reg;
        row_open_next = row_open_reg;
        err_next      = ERR_NONE;
        do_read       = 1'b0;
        do_write      = 1'b0;
        do_refresh    = 1'b0;

        if (bad_cmd) begin
            err_next = ERR_BAD_CMD;
        end else if (cmd != CMD_NOP && in_wait) begin
            err_next = ERR_TIMING;
        end

        unique case (state_reg)
            S_IDLE: begin
                if (!bad_cmd) begin
                    case (cmd)
                        CMD_ACT: begin
                            open_row_next = RA;
                            wait_cnt_next = WAIT_W'(T_RCD - 2);
                            state_next    = S_ACTIVATING;
                        end
                        CMD_REFRESH: begin
                            do_refresh    = 1'b1;
                            wait_cnt_next = WAIT_W'(T_RFC - 2);
                            state_next    = S_REFRESHING;
                        end
                        CMD_READ, CMD_WRITE: err_next = ERR_NO_ROW;
                        default: ;
                    endcase
                end
            end
            S_ACTIVATING: begin
                if (wait_cnt_reg == '0) begin
                    state_next    = S_ACTIVE;
                    row_open_next = 1'b1;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end
            S_ACTIVE: begin
                if (!bad_cmd) begin
                    case (cmd)
                        CMD_READ: begin
                            if (!row_hit) err_next = ERR_ROW_MISS;
                            else          do_read  = 1'b1;
                        end
                        CMD_WRITE: begin
                            if (!row_hit)    err_next = ERR_ROW_MISS;
                            else if (rd_vld) err_next = ERR_BUS;
                            else             do_write = 1'b1;
                        end
                        CMD_PRE: begin
                            row_open_next = 1'b0;
                            wait_cnt_next = WAIT_W'(T_RP - 2);
                            state_next    = S_PRECHARGING;
                        end
                        CMD_ACT:     err_next = ERR_ACT_OPEN;
                        CMD_REFRESH: err_next = ERR_REF_OPEN;
                        default: ;
                    endcase
                end
            end
            S_PRECHARGING, S_REFRESHING: begin
                if (wait_cnt_reg == '0) begin
                    state_next = S_IDLE;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Array port: write from DQ, registered read feeds the head of the CAS pipeline.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[mem_addr] <= DQ;
        end
        if (!rst && do_read) begin
            pipe_data_reg[0] <= mem[mem_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) pipe_vld_reg[0] <= 1'b0;
        else     pipe_vld_reg[0] <= do_read;
    end

    generate
        for (genvar gi = 1; gi < CL; gi++) begin : g_cas
            always_ff @(posedge clk) begin
                if (rst) pipe_vld_reg[gi] <= 1'b0;
                else     pipe_vld_reg[gi] <= pipe_vld_reg[gi-1];
                pipe_data_reg[gi] <= pipe_data_reg[gi-1];
            end
        end
    endgenerate

    assign rd_vld = pipe_vld_reg[CL-1];
    assign DQ     = rd_vld ? pipe_data_reg[CL-1] : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (rst) begin
            err_vld_reg  <= 1'b0;
            err_code_reg <= ERR_NONE;
            err_cnt_reg  <= '0;
        end else begin
            err_vld_reg  <= (err_next != ERR_NONE);
            err_code_reg <= err_next;
            if (err_next != ERR_NONE && err_cnt_reg != 8'hFF) begin
                err_cnt_reg <= err_cnt_reg + 1'b1;
            end
        end
    end

    // Timer parks at the interval so ref_overdue stays set until a REFRESH is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            ref_timer_reg   <= '0;
            ref_overdue_reg <= 1'b0;
        end else if (do_refresh) begin
            ref_timer_reg   <= '0;
            ref_overdue_reg <= 1'b0;
        end else if (state_reg != S_REFRESHING && ref_timer_reg != REF_W'(REF_INTERVAL)) begin
            ref_timer_reg <= ref_timer_reg + 1'b1;
            if (ref_timer_reg == REF_W'(REF_INTERVAL - 1)) begin
                ref_overdue_reg <= 1'b1;
            end
        end
    end

    assign row_open    = row_open_reg;
    assign open_row    = open_row_reg;
    assign ref_overdue = ref_overdue_reg;
    assign err_vld     = err_vld_reg;
    assign err_code    = err_code_reg;
    assign err_cnt     = err_cnt_reg;

endmodule
